// File: rtl/regfile_sb_if.sv
// regfile_sb_if: issue, operand-read, writeback and status bundle for regfile_sb
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0]      ra1_top, ra2_top, ra1_bot, ra2_bot;
    logic [DATA_W-1:0]      rd1_top, rd2_top, rd1_bot, rd2_bot;
    logic                   iss_v_top, iss_v_bot, iss_we_top, iss_we_bot;
    logic [ADDR_W-1:0]      iss_wa_top, iss_wa_bot;
    logic                   stall_top, stall_bot;
    logic                   we3_top, we3_bot;
    logic [ADDR_W-1:0]      wa3_top, wa3_bot;
    logic [DATA_W-1:0]      wd3_top, wd3_bot;
    logic [(1<<ADDR_W)-1:0] busy;
    logic [CNT_W-1:0]       stall_cnt;
    modport master (
        output ra1_top, ra2_top, ra1_bot, ra2_bot,
        output iss_v_top, iss_v_bot, iss_we_top, iss_we_bot, iss_wa_top, iss_wa_bot,
        output we3_top, we3_bot, wa3_top, wa3_bot, wd3_top, wd3_bot,
        input  rd1_top, rd2_top, rd1_bot, rd2_bot, stall_top, stall_bot, busy, stall_cnt
    );
    modport slave (
        input  ra1_top, ra2_top, ra1_bot, ra2_bot,
        input  iss_v_top, iss_v_bot, iss_we_top, iss_we_bot, iss_wa_top, iss_wa_bot,
        input  we3_top, we3_bot, wa3_top, wa3_bot, wd3_top, wd3_bot,
        output rd1_top, rd2_top, rd1_bot, rd2_bot, stall_top, stall_bot, busy, stall_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: dual-issue register file with RAW/WAW scoreboard and saturating stall counter.
// Define REGFILE_SB_BYPASS_EN to forward writeback data and busy-clears combinationally.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_eff, set_v, clr_v;
    logic [CNT_W-1:0]  cnt_q;
    logic              st_top, st_bot, intra_raw, intra_waw;
    logic              we3_t, we3_b;
    logic [ADDR_W-1:0] wa3_t, wa3_b, wa_t, wa_b;
    logic [DATA_W-1:0] wd3_t, wd3_b;
    assign we3_t = bus.we3_top;
    assign we3_b = bus.we3_bot;
    assign wa3_t = bus.wa3_top;
    assign wa3_b = bus.wa3_bot;
    assign wd3_t = bus.wd3_top;
    assign wd3_b = bus.wd3_bot;
    assign wa_t  = bus.iss_wa_top;
    assign wa_b  = bus.iss_wa_bot;
    always_comb begin
        clr_v = '0;
        if (we3_t && wa3_t != '0) clr_v[wa3_t] = 1'b1;
        if (we3_b && wa3_b != '0) clr_v[wa3_b] = 1'b1;
    end
`ifdef REGFILE_SB_BYPASS_EN
    assign busy_eff = busy_q & ~clr_v;
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return a == '0 ? '0 :
               (we3_b && wa3_b == a) ? wd3_b :
               (we3_t && wa3_t == a) ? wd3_t : rf[a];
    endfunction
`else
    assign busy_eff = busy_q;
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return a == '0 ? '0 : rf[a];
    endfunction
`endif
    function automatic logic hz(input logic [ADDR_W-1:0] a);
        return a != '0 && busy_eff[a];
    endfunction
    assign bus.rd1_top = rd(bus.ra1_top);
    assign bus.rd2_top = rd(bus.ra2_top);
    assign bus.rd1_bot = rd(bus.ra1_bot);
    assign bus.rd2_bot = rd(bus.ra2_bot);
    assign st_top = bus.iss_v_top && (hz(bus.ra1_top) || hz(bus.ra2_top) ||
                    (bus.iss_we_top && busy_eff[wa_t]));
    // Younger slot also waits on the older slot's destination within the same pair
    assign intra_raw = bus.iss_v_top && bus.iss_we_top && wa_t != '0 &&
                       (wa_t == bus.ra1_bot || wa_t == bus.ra2_bot);
    assign intra_waw = bus.iss_v_top && bus.iss_we_top && bus.iss_we_bot && wa_t == wa_b;
    assign st_bot = bus.iss_v_bot && (st_top || hz(bus.ra1_bot) || hz(bus.ra2_bot) ||
                    (bus.iss_we_bot && busy_eff[wa_b]) || intra_raw || intra_waw);
    assign bus.stall_top = st_top;
    assign bus.stall_bot = st_bot;
    always_comb begin
        set_v = '0;
        if (bus.iss_v_top && bus.iss_we_top && !st_top && wa_t != '0) set_v[wa_t] = 1'b1;
        if (bus.iss_v_bot && bus.iss_we_bot && !st_bot && wa_b != '0) set_v[wa_b] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (we3_t && wa3_t != '0) rf[wa3_t] <= wd3_t;
            if (we3_b && wa3_b != '0) rf[wa3_b] <= wd3_b;
            busy_q <= (busy_q & ~clr_v) | set_v;
            if ((st_top || st_bot) && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
    end
    assign bus.busy      = busy_q;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed + random checks of regfile_sb against an array-based reference model
module tb_regfile_sb;
    localparam int DW = 32, AW = 5, CW = 4, N = 32, CMAX = (1 << CW) - 1;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus();
    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int tests = 0, fails = 0;
    logic [DW-1:0] mrf [N];
    bit mbusy [N];
    int mcnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit wb_clears(int a);
        return a != 0 && ((bus.we3_top && int'(bus.wa3_top) == a) || (bus.we3_bot && int'(bus.wa3_bot) == a));
    endfunction
    function automatic bit busy_now(int a);
        return mbusy[a] && !(BYP && wb_clears(a));
    endfunction
    function automatic bit haz(int a);
        return a != 0 && busy_now(a);
    endfunction
    function automatic logic [DW-1:0] mread(int a);
        if (a == 0) return '0;
        if (BYP && bus.we3_bot && int'(bus.wa3_bot) == a) return bus.wd3_bot;
        if (BYP && bus.we3_top && int'(bus.wa3_top) == a) return bus.wd3_top;
        return mrf[a];
    endfunction

    task automatic idle();
        {bus.ra1_top, bus.ra2_top, bus.ra1_bot, bus.ra2_bot} = '0;
        {bus.iss_v_top, bus.iss_v_bot, bus.iss_we_top, bus.iss_we_bot} = '0;
        {bus.iss_wa_top, bus.iss_wa_bot} = '0;
        {bus.we3_top, bus.we3_bot, bus.wa3_top, bus.wa3_bot} = '0;
        {bus.wd3_top, bus.wd3_bot} = '0;
    endtask

    // Check combinational outputs mid-cycle, advance the model at the edge, then check registered state
    task automatic tick();
        bit st, sb;
        int wt, wb;
        logic [N-1:0] eb;
        #2;
        wt = int'(bus.iss_wa_top);
        wb = int'(bus.iss_wa_bot);
        st = bus.iss_v_top && (haz(bus.ra1_top) || haz(bus.ra2_top) || (bus.iss_we_top && busy_now(wt)));
        sb = bus.iss_v_bot && (st || haz(bus.ra1_bot) || haz(bus.ra2_bot) ||
             (bus.iss_we_bot && busy_now(wb)) ||
             (bus.iss_v_top && bus.iss_we_top && wt != 0 && (wt == int'(bus.ra1_bot) || wt == int'(bus.ra2_bot))) ||
             (bus.iss_v_top && bus.iss_we_top && bus.iss_we_bot && wt == wb));
        check("rd1_top", bus.rd1_top, mread(bus.ra1_top));
        check("rd2_top", bus.rd2_top, mread(bus.ra2_top));
        check("rd1_bot", bus.rd1_bot, mread(bus.ra1_bot));
        check("rd2_bot", bus.rd2_bot, mread(bus.ra2_bot));
        check("stall_top", bus.stall_top, st);
        check("stall_bot", bus.stall_bot, sb);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin mrf[i] = '0; mbusy[i] = 0; end
            mcnt = 0;
        end else begin
            if (bus.we3_top && bus.wa3_top != 0) begin mrf[bus.wa3_top] = bus.wd3_top; mbusy[bus.wa3_top] = 0; end
            if (bus.we3_bot && bus.wa3_bot != 0) begin mrf[bus.wa3_bot] = bus.wd3_bot; mbusy[bus.wa3_bot] = 0; end
            if (bus.iss_v_top && bus.iss_we_top && !st && wt != 0) mbusy[wt] = 1;
            if (bus.iss_v_bot && bus.iss_we_bot && !sb && wb != 0) mbusy[wb] = 1;
            if ((st || sb) && mcnt < CMAX) mcnt++;
        end
        #1;
        for (int i = 0; i < N; i++) eb[i] = mbusy[i];
        check("busy", bus.busy, eb);
        check("stall_cnt", bus.stall_cnt, mcnt);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin mrf[i] = '0; mbusy[i] = 0; end
        idle();
        rst = 1; tick(); rst = 0;
        // Reset clears a written register
        bus.we3_top = 1; bus.wa3_top = 5; bus.wd3_top = 32'hDEADBEEF; tick();
        idle(); bus.ra1_top = 5; tick();
        check("r5_written", bus.rd1_top, 32'hDEADBEEF);
        rst = 1; tick(); rst = 0;
        check("r5_after_rst", bus.rd1_top, 0);
        check("busy_after_rst", bus.busy, 0);
        // Register 0 ignores writes
        idle(); bus.we3_top = 1; bus.wa3_top = 0; bus.wd3_top = 32'h1234; tick();
        idle(); tick();
        // Dual write to the same register: bot wins
        bus.we3_top = 1; bus.wa3_top = 7; bus.wd3_top = 32'h11;
        bus.we3_bot = 1; bus.wa3_bot = 7; bus.wd3_bot = 32'h22; tick();
        idle(); bus.ra1_top = 7; tick();
        check("r7_bot_wins", bus.rd1_top, 32'h22);
        // RAW through the scoreboard
        idle(); bus.iss_v_top = 1; bus.iss_we_top = 1; bus.iss_wa_top = 3; tick();
        idle(); bus.iss_v_top = 1; bus.iss_v_bot = 1; bus.ra1_top = 3; tick();
        bus.we3_top = 1; bus.wa3_top = 3; bus.wd3_top = 32'h55; tick();
        bus.we3_top = 0; tick();
        check("r3_released", bus.rd1_top, 32'h55);
        // Intra-pair RAW with a clear scoreboard
        idle(); bus.iss_v_top = 1; bus.iss_we_top = 1; bus.iss_wa_top = 4;
        bus.iss_v_bot = 1; bus.ra1_bot = 4; tick();
        idle(); tick();
        // Set wins over clear
        bus.iss_v_top = 1; bus.iss_we_top = 1; bus.iss_wa_top = 9;
        bus.we3_bot = 1; bus.wa3_bot = 9; bus.wd3_bot = 32'h99; tick();
        check("busy9_set_wins", bus.busy[9], 1'b1);
        idle(); tick();
        // Saturating stall counter
        rst = 1; tick(); rst = 0;
        bus.iss_v_top = 1; bus.iss_we_top = 1; bus.iss_wa_top = 3; tick();
        idle(); bus.iss_v_top = 1; bus.ra1_top = 3;
        repeat (20) tick();
        check("cnt_saturated", bus.stall_cnt, CMAX);
        // Random traffic on a small address window to provoke hazards
        repeat (400) begin
            rst = ($urandom % 60) == 0;
            bus.ra1_top = AW'($urandom_range(0, 7)); bus.ra2_top = AW'($urandom_range(0, 7));
            bus.ra1_bot = AW'($urandom_range(0, 7)); bus.ra2_bot = AW'($urandom_range(0, 7));
            bus.iss_v_top = $urandom_range(0, 1) == 1; bus.iss_v_bot = $urandom_range(0, 1) == 1;
            bus.iss_we_top = $urandom_range(0, 3) != 0; bus.iss_we_bot = $urandom_range(0, 3) != 0;
            bus.iss_wa_top = AW'($urandom_range(0, 7)); bus.iss_wa_bot = AW'($urandom_range(0, 7));
            bus.we3_top = $urandom_range(0, 1) == 1; bus.we3_bot = $urandom_range(0, 1) == 1;
            bus.wa3_top = AW'($urandom_range(0, 7)); bus.wa3_bot = AW'($urandom_range(0, 7));
            bus.wd3_top = $urandom; bus.wd3_bot = $urandom;
            tick();
        end
        rst = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
